// File: rtl/cmp_seq_ctrl.sv
// rtl/cmp_seq_ctrl.sv - batch max/min finder that time-shares one external magnitude comparator
module cmp_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int COUNT = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] CMP_A,
  output logic [WIDTH-1:0] CMP_B,
  input  logic             CMP_LT,
  input  logic             CMP_GT,
  input  logic             CMP_EQ,
  output logic [WIDTH-1:0] MAX_OUT,
  output logic [WIDTH-1:0] MIN_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_FETCH,
    S_CMP_MAX,
    S_CMP_MIN,
    S_DONE
  } state_t;

  localparam logic [7:0] COUNT_L = 8'(COUNT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [7:0]       count_q, count_d;
  logic             err_q, err_d;
  logic             cmp_ok;

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    min_d    = min_q;
    cur_d    = cur_q;
    count_d  = count_q;
    err_d    = err_q;
    IN_READY = 1'b0;
    CMP_A    = '0;
    CMP_B    = '0;
    // An inconsistent comparator answer must never move the running extremes.
    cmp_ok   = (CMP_LT & ~CMP_GT & ~CMP_EQ) |
               (~CMP_LT & CMP_GT & ~CMP_EQ) |
               (~CMP_LT & ~CMP_GT & CMP_EQ);

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_FIRST;
          err_d   = 1'b0;
        end
      end
      S_FIRST: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          max_d   = IN_DATA;
          min_d   = IN_DATA;
          count_d = 8'd1;
          state_d = (COUNT_L == 8'd1) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        IN_READY = 1'b1;
        if (IN_VALID) begin
          cur_d   = IN_DATA;
          count_d = count_q + 8'd1;
          state_d = S_CMP_MAX;
        end
      end
      S_CMP_MAX: begin
        CMP_A   = cur_q;
        CMP_B   = max_q;
        if (!cmp_ok) begin
          err_d = 1'b1;
        end else if (CMP_GT) begin
          max_d = cur_q;
        end
        state_d = S_CMP_MIN;
      end
      S_CMP_MIN: begin
        CMP_A   = cur_q;
        CMP_B   = min_q;
        if (!cmp_ok) begin
          err_d = 1'b1;
        end else if (CMP_LT) begin
          min_d = cur_q;
        end
        state_d = (count_q == COUNT_L) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      min_q   <= '0;
      cur_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      cur_q   <= cur_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign MAX_OUT = max_q;
  assign MIN_OUT = min_q;
  assign ERR     = err_q;
  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = (state_q == S_DONE);

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb/tb_cmp_seq_ctrl.sv - bench for cmp_seq_ctrl with COUNT=4, 3 and 1 instances
module tb_cmp_seq_ctrl;

  typedef struct packed {
    logic [1:0]  inst;
    logic [2:0]  n;
    logic [15:0] w;
    logic [15:0] gap;
    logic [3:0]  emax;
    logic [3:0]  emin;
    logic        eerr;
    logic [2:0]  fault;
    logic [3:0]  fmax;
    logic [1:0]  lat;
    logic        spam;
  } vec_t;

  typedef struct packed {
    logic [3:0] mx;
    logic [3:0] mn;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] start;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [3:0] in_data [3];
  logic [3:0] cmp_a   [3];
  logic [3:0] cmp_b   [3];
  logic [2:0] cmp_lt;
  logic [2:0] cmp_gt;
  logic [2:0] cmp_eq;
  logic [2:0] flt;
  logic [3:0] max_out [3];
  logic [3:0] min_out [3];
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] err;

  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   eq_cnt   = 0;
  int   neq_cnt  = 0;
  int   done_cnt;
  int   done_cyc;
  int   busy_bad;
  exp_t sbq [$];
  vec_t vecs [8];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CNT = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
    // Reference comparator; flt forces the illegal LT=GT=1 answer.
    assign cmp_lt[g] = flt[g] ? 1'b1 : (cmp_a[g] < cmp_b[g]);
    assign cmp_gt[g] = flt[g] ? 1'b1 : (cmp_a[g] > cmp_b[g]);
    assign cmp_eq[g] = flt[g] ? 1'b0 : (cmp_a[g] == cmp_b[g]);

    cmp_seq_ctrl #(.WIDTH(4), .COUNT(CNT)) u_dut (
      .CLK      (clk),
      .RST      (rst),
      .START    (start[g]),
      .IN_VALID (in_valid[g]),
      .IN_READY (in_ready[g]),
      .IN_DATA  (in_data[g]),
      .CMP_A    (cmp_a[g]),
      .CMP_B    (cmp_b[g]),
      .CMP_LT   (cmp_lt[g]),
      .CMP_GT   (cmp_gt[g]),
      .CMP_EQ   (cmp_eq[g]),
      .MAX_OUT  (max_out[g]),
      .MIN_OUT  (min_out[g]),
      .BUSY     (busy[g]),
      .DONE     (done[g]),
      .ERR      (err[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmp_a[0] != 4'd0) begin
      if (cmp_eq[0]) eq_cnt <= eq_cnt + 1;
      else neq_cnt <= neq_cnt + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int inst, input int n, input logic [15:0] w,
                              input logic [15:0] gap, input logic [3:0] emax,
                              input logic [3:0] emin, input logic eerr, input int fault,
                              input logic [3:0] fmax, input int lat, input logic spam);
    vec_t v;
    v.inst  = 2'(inst);
    v.n     = 3'(n);
    v.w     = w;
    v.gap   = gap;
    v.emax  = emax;
    v.emin  = emin;
    v.eerr  = eerr;
    v.fault = 3'(fault);
    v.fmax  = fmax;
    v.lat   = 2'(lat);
    v.spam  = spam;
    return v;
  endfunction

  // Samples at the falling edge, scores any DONE against the queue, then steps past the next rising edge.
  task automatic observe(input int i, output logic rdy);
    exp_t e;
    @(negedge clk);
    rdy = in_ready[i];
    if (done_cnt == 0 && !busy[i]) busy_bad++;
    if (done[i]) begin
      done_cnt++;
      done_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("max_out", int'(max_out[i]), int'(e.mx));
        chk("min_out", int'(min_out[i]), int'(e.mn));
        chk("err", int'(err[i]), int'(e.e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic feed_word(input int i, input logic [3:0] d, input int gap);
    logic r;
    int   wd;
    in_valid[i] = 1'b0;
    for (int g = 0; g < gap; g++) observe(i, r);
    in_data[i]  = d;
    in_valid[i] = 1'b1;
    wd = 0;
    do begin
      observe(i, r);
      wd++;
    end while (!r && wd < 40);
    if (!r) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int   i;
    int   last_acc;
    int   wd;
    logic r;
    i = int'(v.inst);
    sbq.push_back({v.emax, v.emin, v.eerr});
    done_cnt = 0;
    busy_bad = 0;
    last_acc = 0;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    chk("err_clear_on_start", int'(err[i]), 0);
    for (int k = 0; k < int'(v.n); k++) begin
      feed_word(i, v.w[4*k +: 4], int'(v.gap[4*k +: 4]));
      last_acc = cyc;
      if (v.spam) start[i] = 1'b1;
      if (int'(v.fault) == k + 1) begin
        flt[i] = 1'b1;
        observe(i, r);
        flt[i] = 1'b0;
        chk("fault_max_hold", int'(max_out[i]), int'(v.fmax));
        chk("fault_err_set", int'(err[i]), 1);
      end
    end
    in_valid[i] = 1'b0;
    wd = 0;
    while (done_cnt == 0 && wd < 20) begin
      observe(i, r);
      wd++;
    end
    start[i] = 1'b0;
    repeat (3) observe(i, r);
    chk("done_once", done_cnt, 1);
    chk("done_latency", done_cyc - last_acc, int'(v.lat));
    chk("busy_through_batch", busy_bad, 0);
    chk("idle_busy", int'(busy[i]), 0);
    chk("idle_ready", int'(in_ready[i]), 0);
  endtask

  initial begin
    int   e0;
    int   n0;
    logic r;
    rst      = 1'b1;
    start    = '0;
    in_valid = '0;
    flt      = '0;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    done_cnt = 0;
    busy_bad = 0;
    done_cyc = 0;

    vecs[0] = mk(0, 4, 16'h90F3, 16'h0000, 4'hF, 4'h0, 1'b0, 0, 4'h0, 2, 1'b0);
    vecs[1] = mk(0, 4, 16'h7777, 16'h0000, 4'h7, 4'h7, 1'b0, 0, 4'h0, 2, 1'b0);
    vecs[2] = mk(1, 3, 16'h01BA, 16'h0520, 4'hB, 4'h1, 1'b0, 0, 4'h0, 2, 1'b0);
    vecs[3] = mk(0, 4, 16'h90F3, 16'h0000, 4'h9, 4'h0, 1'b1, 2, 4'h3, 2, 1'b0);
    vecs[4] = mk(0, 4, 16'h82C5, 16'h0000, 4'hC, 4'h2, 1'b0, 0, 4'h0, 2, 1'b1);
    vecs[5] = mk(2, 1, 16'h0005, 16'h0000, 4'h5, 4'h5, 1'b0, 0, 4'h0, 0, 1'b0);
    vecs[6] = mk(2, 1, 16'h0000, 16'h0003, 4'h0, 4'h0, 1'b0, 0, 4'h0, 0, 1'b1);
    vecs[7] = mk(1, 3, 16'h0E4D, 16'h0013, 4'hE, 4'h4, 1'b0, 0, 4'h0, 2, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", int'(in_ready[i]), 0);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_err", int'(err[i]), 0);
      chk("rst_max", int'(max_out[i]), 0);
      chk("rst_min", int'(min_out[i]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      e0 = eq_cnt;
      n0 = neq_cnt;
      run_vec(vecs[v]);
      if (v == 1) begin
        chk("ties_eq_compares", eq_cnt - e0, 6);
        chk("ties_neq_compares", neq_cnt - n0, 0);
      end
    end

    // Reset held two cycles starting in CMP_MAX of the second word.
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    feed_word(0, 4'h2, 0);
    feed_word(0, 4'h6, 0);
    chk("pre_rst_cmp_a", int'(cmp_a[0]), 6);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst         = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", int'(in_ready[0]), 0);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_done", int'(done[0]), 0);
    chk("mid_rst_max", int'(max_out[0]), 0);
    chk("mid_rst_min", int'(min_out[0]), 0);
    chk("mid_rst_cmp_a", int'(cmp_a[0]), 0);
    chk("mid_rst_cmp_b", int'(cmp_b[0]), 0);
    @(posedge clk);
    #1;
    run_vec(vecs[0]);
    run_vec(vecs[7]);

    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
